// File: rtl/snake_tile_scheduler.sv
// Tile-map owner for the snake display: Avalon-fed write FIFO, single-port tile RAM
// arbitration (display prefetch first), and per-pixel sprite select/address generation.
module snake_tile_scheduler #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned COLS          = 40,
  parameter int unsigned ROWS          = 30,
  parameter int unsigned PREFETCH_SLOT = 28
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [2:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        blank_n,
  output logic [4:0]  sprite_sel,
  output logic [7:0]  sprite_addr,
  output logic        busy
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned CELLS = COLS * ROWS;

  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [7:0]    COLS8     = 8'(COLS);
  localparam logic [7:0]    ROWS8     = 8'(ROWS);
  localparam logic [5:0]    COLS6     = 6'(COLS);
  localparam logic [4:0]    ROWS5     = 5'(ROWS);
  localparam logic [10:0]   COLS11    = 11'(COLS);
  localparam logic [10:0]   LAST_CELL = 11'(CELLS - 1);
  localparam logic [4:0]    SLOT_PF   = 5'(PREFETCH_SLOT);
  localparam logic [4:0]    SLOT_CAP  = 5'(PREFETCH_SLOT + 1);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t        state_q, state_d;
  logic [10:0]   clr_cnt_q, clr_cnt_d;
  logic [7:0]    col_q, row_q;
  logic          range_err_q, range_err_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    readdata_q;

  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [4:0]    tile_mem [CELLS];
  logic [4:0]    rdata_q;
  logic          pf_valid_q;
  logic [4:0]    next_code_q, cur_code_q;
  logic [4:0]    sprite_sel_q;
  logic [7:0]    sprite_addr_q;

  logic          bus_wr, commit, clear_req, stat_rd;
  logic          in_range, fifo_full, fifo_empty, push, pop;
  logic [10:0]   commit_addr;
  logic          disp_slot, wslot;
  logic [5:0]    pf_col;
  logic [4:0]    pf_row;
  logic [9:0]    next_v;
  logic          pf_valid;
  logic [10:0]   pf_addr;
  logic          ram_we, ram_re;
  logic [10:0]   ram_addr;
  logic [4:0]    ram_wdata;
  logic [15:0]   fifo_head;

  assign bus_wr    = chipselect & write;
  assign commit    = bus_wr && (address == 3'd2);
  assign clear_req = bus_wr && (address == 3'd3);
  assign stat_rd   = chipselect && read && (address == 3'd4);

  assign in_range    = (col_q < COLS8) && (row_q < ROWS8);
  assign commit_addr = 11'(row_q[4:0]) * COLS11 + 11'(col_q[5:0]);
  assign fifo_full   = (cnt_q == DEPTH_C);
  assign fifo_empty  = (cnt_q == '0);
  assign fifo_head   = fifo_mem[rd_ptr_q];

  assign disp_slot = (hcount[4:0] == SLOT_PF);
  assign wslot     = ~disp_slot;
  assign push      = commit & in_range & ~fifo_full;
  assign pop       = (state_q == S_IDLE) & wslot & ~fifo_empty;

  // Prefetch target is the tile after the current one; the last hcount tile wraps to next line.
  always_comb begin
    next_v = (vcount == 10'd524) ? '0 : vcount + 10'd1;
    pf_col = hcount[10:5] + 6'd1;
    pf_row = vcount[8:4];
    if (hcount[10:5] == 6'd49) begin
      pf_col = '0;
      pf_row = next_v[8:4];
    end
    pf_valid = (pf_row < ROWS5) && (pf_col < COLS6);
    pf_addr  = 11'(pf_row) * COLS11 + 11'(pf_col);
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = pf_addr;
    ram_wdata = '0;
    if (disp_slot) begin
      ram_re = pf_valid;
    end else if (state_q == S_CLEAR) begin
      ram_we   = 1'b1;
      ram_addr = clr_cnt_q;
    end else if (pop) begin
      ram_we    = 1'b1;
      ram_addr  = fifo_head[15:5];
      ram_wdata = fifo_head[4:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (clear_req) begin
      state_d   = S_CLEAR;
      clr_cnt_d = '0;
    end else if (state_q == S_CLEAR && wslot) begin
      if (clr_cnt_q == LAST_CELL) begin
        state_d   = S_IDLE;
        clr_cnt_d = '0;
      end else begin
        clr_cnt_d = clr_cnt_q + 11'd1;
      end
    end
  end

  // Sticky bits: a status read clears them, but an error on the same edge still latches.
  always_comb begin
    range_err_d = range_err_q;
    overflow_d  = overflow_q;
    if (stat_rd) begin
      range_err_d = 1'b0;
      overflow_d  = 1'b0;
    end
    if (commit && !in_range)             range_err_d = 1'b1;
    if (commit && in_range && fifo_full) overflow_d  = 1'b1;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_CLEAR;
      clr_cnt_q   <= '0;
      col_q       <= '0;
      row_q       <= '0;
      range_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      readdata_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      range_err_q <= range_err_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      if (bus_wr && address == 3'd0) col_q <= writedata;
      if (bus_wr && address == 3'd1) row_q <= writedata;
      if (stat_rd) readdata_q <= {5'b0, range_err_q, overflow_q, busy};
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {commit_addr, writedata[4:0]};
  end

  always_ff @(posedge clk) begin
    if (ram_we) tile_mem[ram_addr] <= ram_wdata;
    if (ram_re) rdata_q <= tile_mem[ram_addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pf_valid_q    <= 1'b0;
      next_code_q   <= '0;
      cur_code_q    <= '0;
      sprite_sel_q  <= '0;
      sprite_addr_q <= '0;
    end else begin
      if (disp_slot)                pf_valid_q  <= pf_valid;
      if (hcount[4:0] == SLOT_CAP)  next_code_q <= pf_valid_q ? rdata_q : '0;
      if (hcount[4:0] == 5'd31)     cur_code_q  <= next_code_q;
      sprite_sel_q  <= (blank_n && cur_code_q <= 5'd16) ? cur_code_q : '0;
      sprite_addr_q <= {vcount[3:0], hcount[4:1]};
    end
  end

  assign busy        = (state_q == S_CLEAR) | ~fifo_empty;
  assign readdata    = readdata_q;
  assign sprite_sel  = sprite_sel_q;
  assign sprite_addr = sprite_addr_q;

endmodule

// File: tb/tb_snake_tile_scheduler.sv
// Directed bench for snake_tile_scheduler: walks the VGA counters over chosen tiles
// and checks bus status, clear/drain timing and per-pixel sprite outputs.
module tb_snake_tile_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect, write, read;
  logic [2:0]  address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        blank_n;
  logic [4:0]  sprite_sel;
  logic [7:0]  sprite_addr;
  logic        busy;

  int n_asrt = 0;
  int n_fail = 0;
  int ph, pv;
  int n;

  snake_tile_scheduler #(
    .FIFO_DEPTH(4), .COLS(40), .ROWS(30), .PREFETCH_SLOT(28)
  ) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .hcount(hcount), .vcount(vcount), .blank_n(blank_n),
    .sprite_sel(sprite_sel), .sprite_addr(sprite_addr), .busy(busy)
  );

  always #10 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int disp(input int c);
    return (c <= 16) ? c : 0;
  endfunction

  function automatic int exp_addr(input int h, input int v);
    return ((v & 15) << 4) | ((h >> 1) & 15);
  endfunction

  // One clock: outputs now reflect (ph, pv); counters step like vga_counters.
  task automatic tick();
    @(negedge clk);
    ph = int'(hcount);
    pv = int'(vcount);
    if (hcount == 11'd1599) begin
      hcount = '0;
      vcount = (vcount == 10'd524) ? '0 : vcount + 10'd1;
    end else begin
      hcount = hcount + 11'd1;
    end
    #1;
    if (hcount[4:0] == 5'd28) chk("slot_we", {31'b0, dut.ram_we}, 32'd0);
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] a);
    chipselect = 1'b1; read = 1'b1; address = a;
    tick();
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic put_tile(input int c, input int r, input int code);
    bus_wr(3'd0, 8'(c));
    bus_wr(3'd1, 8'(r));
    bus_wr(3'd2, 8'(code));
  endtask

  task automatic wait_idle(input int limit, output int cnt);
    cnt = 0;
    while (busy && cnt < limit) begin
      tick();
      cnt++;
    end
    chk("idle_reached", {31'b0, busy}, 32'd0);
  endtask

  task automatic check_line(input int v, input int col, input int c0, input int c1);
    hcount = 11'(col * 32 - 8);
    vcount = 10'(v);
    repeat (8) tick();
    for (int i = 0; i < 64; i++) begin
      tick();
      chk($sformatf("sel v%0d h%0d", pv, ph), sprite_sel, disp(i < 32 ? c0 : c1));
      chk($sformatf("addr v%0d h%0d", pv, ph), sprite_addr, exp_addr(ph, pv));
    end
  endtask

  task automatic check_wrap(input int v, input int c0, input int c1);
    hcount = 11'd1590;
    vcount = 10'(v);
    repeat (10) tick();
    for (int i = 0; i < 64; i++) begin
      tick();
      chk($sformatf("wrap sel v%0d h%0d", pv, ph), sprite_sel, disp(i < 32 ? c0 : c1));
    end
  endtask

  initial begin
    reset = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = '0; writedata = '0; hcount = '0; vcount = '0; blank_n = 1'b1;

    repeat (3) tick();
    chk("rst_sel", sprite_sel, 0);
    chk("rst_addr", sprite_addr, 0);
    chk("rst_readdata", readdata, 0);
    chk("rst_busy", busy, 1);

    reset = 1'b1;
    wait_idle(2000, n);
    chk("first_clear_len", (n >= 1236 && n <= 1242), 1);
    bus_rd(3'd4);
    chk("status_idle", readdata, 8'h00);
    check_line(100, 20, 0, 0);
    check_line(470, 38, 0, 0);

    put_tile(5, 10, 1);
    wait_idle(100, n);
    check_line(160, 5, 1, 0);
    check_line(175, 5, 1, 0);
    check_line(160, 4, 0, 1);
    check_line(176, 5, 0, 0);
    check_line(159, 5, 0, 0);
    hcount = 11'd152; vcount = 10'd165;
    repeat (8) tick();
    blank_n = 1'b0;
    repeat (4) begin
      tick();
      chk("blank_sel", sprite_sel, 0);
    end
    blank_n = 1'b1;

    bus_wr(3'd3, 8'd0);
    bus_wr(3'd0, 8'd7);
    bus_wr(3'd1, 8'd12);
    for (int k = 5; k <= 9; k++) bus_wr(3'd2, 8'(k));
    bus_rd(3'd4);
    chk("status_overflow", readdata, 8'h03);
    wait_idle(2000, n);
    bus_rd(3'd4);
    chk("status_after_drain", readdata, 8'h00);
    check_line(192, 7, 8, 0);
    check_line(160, 5, 0, 0);

    put_tile(40, 0, 9);
    chk("range_no_push", busy, 0);
    bus_rd(3'd4);
    chk("status_range_col", readdata, 8'h04);
    put_tile(0, 30, 9);
    chk("range_row_no_push", busy, 0);
    bus_rd(3'd4);
    chk("status_range_row", readdata, 8'h04);

    put_tile(0, 0, 20);
    put_tile(1, 0, 16);
    put_tile(2, 0, 17);
    put_tile(0, 11, 3);
    wait_idle(100, n);
    check_wrap(524, 20, 16);
    check_line(0, 2, 17, 0);
    check_wrap(175, 3, 0);

    bus_wr(3'd3, 8'd0);
    put_tile(3, 20, 5);
    bus_wr(3'd0, 8'd4);
    bus_wr(3'd2, 8'd6);
    bus_wr(3'd3, 8'd0);
    chk("middrain_busy", busy, 1);
    wait_idle(2000, n);
    chk("middrain_len", (n >= 1238 && n <= 1246), 1);
    check_line(320, 3, 5, 6);
    check_wrap(175, 0, 0);

    hcount = 11'd80; vcount = 10'd320;
    repeat (21) tick();
    chk("pre_reset_sel", sprite_sel, 5);
    bus_wr(3'd3, 8'd0);
    bus_rd(3'd4);
    chk("status_clearing", readdata, 8'h01);
    reset = 1'b0;
    #1;
    chk("async_rst_readdata", readdata, 0);
    chk("async_rst_sel", sprite_sel, 0);
    chk("async_rst_addr", sprite_addr, 0);
    chk("async_rst_busy", busy, 1);
    repeat (3) tick();
    reset = 1'b1;
    wait_idle(2000, n);
    chk("restart_clear_len", (n >= 1236 && n <= 1242), 1);
    check_line(320, 3, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
